// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Initiator side of the CPU data-memory interface. Accepts a single
//            load/store at a time, extracts and extends sub-word loads, and
//            performs read-modify-write for byte/halfword stores against a
//            word-organised memory with one cycle of read latency.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched request fields
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_sign;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;

  // Result / write-buffer registers
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_wbuf;

  logic              w_accept;
  logic              w_misalign;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load_val;
  logic [DATA_W-1:0] w_merged;

  // Address bits above the decoded space alias; they are intentionally dropped.
  logic w_unused_addr;
  assign w_unused_addr = ^req_addr[31:ADDR_W];

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Alignment / legality check on the incoming request
  always_comb begin
    w_misalign = 1'b0;
    case (req_size)
      c_SIZE_BYTE: w_misalign = 1'b0;
      c_SIZE_HALF: w_misalign = req_addr[0];
      c_SIZE_WORD: w_misalign = (req_addr[1:0] != 2'b00);
      default:     w_misalign = 1'b1;
    endcase
  end

  // Lane extraction and extension of the returned read word
  always_comb begin
    w_byte = mem_rdata[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = mem_rdata[7:0];
      2'd1: w_byte = mem_rdata[15:8];
      2'd2: w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_load_val = mem_rdata;
    case (r_size)
      c_SIZE_BYTE: w_load_val = {{24{r_sign & w_byte[7]}}, w_byte};
      c_SIZE_HALF: w_load_val = {{16{r_sign & w_half[15]}}, w_half};
      default:     w_load_val = mem_rdata;
    endcase
  end

  // Merge of sub-word store data into the word read back from memory
  always_comb begin
    w_merged = mem_rdata;
    if (r_size == c_SIZE_HALF) begin
      if (r_addr[1]) w_merged = {r_wdata[15:0], mem_rdata[15:0]};
      else           w_merged = {mem_rdata[31:16], r_wdata[15:0]};
    end else begin
      case (r_addr[1:0])
        2'd0: w_merged = {mem_rdata[31:8], r_wdata[7:0]};
        2'd1: w_merged = {mem_rdata[31:16], r_wdata[7:0], mem_rdata[7:0]};
        2'd2: w_merged = {mem_rdata[31:24], r_wdata[7:0], mem_rdata[15:0]};
        default: w_merged = {r_wdata[7:0], mem_rdata[23:0]};
      endcase
    end
  end

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Capture request fields at the acceptance edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_sign  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_size  <= req_size;
      r_sign  <= req_sign;
      r_addr  <= req_addr[ADDR_W-1:0];
      r_wdata <= req_wdata;
      r_err   <= w_misalign;
    end
  end

  // Load result and merged store word are captured while the read data is valid;
  // the result is cleared on acceptance so stores and errors return zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rdata <= '0;
      r_wbuf  <= '0;
    end else if (w_accept) begin
      r_rdata <= '0;
    end else if (r_state == S_WAIT) begin
      if (r_we) r_wbuf  <= w_merged;
      else      r_rdata <= w_load_val;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    resp_rdata  = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_misalign)                            w_state_nxt = S_DONE;
          else if (req_we && req_size == c_SIZE_WORD) w_state_nxt = S_WR;
          else                                       w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        mem_re      = 1'b1;
        mem_addr    = r_addr[ADDR_W-1:2];
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_state_nxt = r_we ? S_WR : S_DONE;
      end
      S_WR: begin
        mem_we      = 1'b1;
        mem_addr    = r_addr[ADDR_W-1:2];
        mem_wdata   = (r_size == c_SIZE_WORD) ? r_wdata : r_wbuf;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        resp_valid  = 1'b1;
        resp_err    = r_err;
        resp_rdata  = r_rdata;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit with a word
//            memory model of one-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks;
  int failures;

  // Observations of the most recent request
  int          o_lat;
  int          o_nre;
  int          o_nwe;
  int          o_nboth;
  int          o_nresp;
  logic        o_err;
  logic [31:0] o_rdata;
  logic [9:0]  o_re_addr;
  logic [9:0]  o_we_addr;
  logic [31:0] o_we_data;

  logic [31:0] mem [0:1023];

  mem_access_unit #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: write at the edge, registered read data
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Issue one request, then observe 8 cycles after the acceptance edge
  task automatic do_req(input logic we, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int guard;
    @(negedge clk);
    req_we = we; req_size = size; req_sign = sign; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0BAD_F00D;
    req_size  = 2'b11;
    o_lat = -1; o_nre = 0; o_nwe = 0; o_nboth = 0; o_nresp = 0;
    o_err = 1'b0; o_rdata = 32'h0; o_re_addr = '0; o_we_addr = '0; o_we_data = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_re) begin o_nre++; o_re_addr = mem_addr; end
      if (mem_we) begin o_nwe++; o_we_addr = mem_addr; o_we_data = mem_wdata; end
      if (mem_re && mem_we) o_nboth++;
      if (resp_valid) begin
        o_nresp++;
        if (o_lat < 0) begin o_lat = c; o_err = resp_err; o_rdata = resp_rdata; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_sign = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL rst_resp_err got %b want 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); end
    checks++; if ({mem_re, mem_we} !== 2'b00) begin failures++; $display("FAIL rst_strobes got %b want 00", {mem_re, mem_we}); end
    checks++; if (mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_bus got %h/%h want 0/0", mem_addr, mem_wdata); end
    reset = 1'b1;
  endtask

  task automatic test_word_store();
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checks++; if (o_lat !== 2) begin failures++; $display("FAIL wst_latency got %0d want 2", o_lat); end
    checks++; if (o_nwe !== 1 || o_nre !== 0) begin failures++; $display("FAIL wst_strobes got we=%0d re=%0d want 1/0", o_nwe, o_nre); end
    checks++; if (o_we_addr !== 10'h004) begin failures++; $display("FAIL wst_addr got %h want 004", o_we_addr); end
    checks++; if (o_we_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wst_data got %h want deadbeef", o_we_data); end
    checks++; if (o_err !== 1'b0 || o_nresp !== 1) begin failures++; $display("FAIL wst_resp got err=%b n=%0d want 0/1", o_err, o_nresp); end
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB);
    checks++; if (o_we_data !== 32'h8899AABB) begin failures++; $display("FAIL wst2_data got %h want 8899aabb", o_we_data); end
    do_req(1'b1, 2'b10, 1'b0, 32'h00, 32'h80011234);
  endtask

  task automatic test_byte_load();
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    checks++; if (o_rdata !== 32'hFFFFFFAA) begin failures++; $display("FAIL lb_signed got %h want ffffffaa", o_rdata); end
    checks++; if (o_lat !== 3) begin failures++; $display("FAIL lb_latency got %0d want 3", o_lat); end
    checks++; if (o_nre !== 1 || o_re_addr !== 10'h004 || o_nwe !== 0) begin failures++; $display("FAIL lb_read got re=%0d addr=%h we=%0d want 1/004/0", o_nre, o_re_addr, o_nwe); end
    do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    checks++; if (o_rdata !== 32'h000000AA) begin failures++; $display("FAIL lb_unsigned got %h want 000000aa", o_rdata); end
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    checks++; if (o_rdata !== 32'hFFFF8899) begin failures++; $display("FAIL lh_signed got %h want ffff8899", o_rdata); end
  endtask

  task automatic test_subword_store();
    do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h12345655);
    checks++; if (o_lat !== 4) begin failures++; $display("FAIL sb_latency got %0d want 4", o_lat); end
    checks++; if (o_nre !== 1 || o_nwe !== 1 || o_nboth !== 0) begin failures++; $display("FAIL sb_strobes got re=%0d we=%0d both=%0d want 1/1/0", o_nre, o_nwe, o_nboth); end
    checks++; if (o_we_data !== 32'h8855AABB || o_we_addr !== 10'h004) begin failures++; $display("FAIL sb_merge got %h@%h want 8855aabb@004", o_we_data, o_we_addr); end
    checks++; if (o_rdata !== 32'h0 || o_err !== 1'b0) begin failures++; $display("FAIL sb_resp got %h err=%b want 0/0", o_rdata, o_err); end
  endtask

  task automatic test_errors();
    do_req(1'b0, 2'b01, 1'b1, 32'h13, 32'h0);
    checks++; if (o_lat !== 1 || o_err !== 1'b1) begin failures++; $display("FAIL err_half got lat=%0d err=%b want 1/1", o_lat, o_err); end
    checks++; if (o_nre !== 0 || o_nwe !== 0 || o_rdata !== 32'h0) begin failures++; $display("FAIL err_half_side got re=%0d we=%0d rd=%h want 0/0/0", o_nre, o_nwe, o_rdata); end
    do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF);
    checks++; if (o_lat !== 1 || o_err !== 1'b1 || o_nwe !== 0) begin failures++; $display("FAIL err_word got lat=%0d err=%b we=%0d want 1/1/0", o_lat, o_err, o_nwe); end
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    checks++; if (o_err !== 1'b1 || o_nre !== 0) begin failures++; $display("FAIL err_size got err=%b re=%0d want 1/0", o_err, o_nre); end
  endtask

  task automatic test_reset_mid();
    int nwe;
    int nresp;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b01; req_sign = 1'b0; req_addr = 32'h12; req_wdata = 32'h00007777;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);   // RD
    @(negedge clk);   // WAIT
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1 || mem_we !== 1'b0 || mem_re !== 1'b0 || resp_valid !== 1'b0) begin failures++; $display("FAIL rmid_outputs got rdy=%b we=%b re=%b rv=%b want 1/0/0/0", req_ready, mem_we, mem_re, resp_valid); end
    checks++; if (mem_addr !== 10'h0 || mem_wdata !== 32'h0 || resp_rdata !== 32'h0) begin failures++; $display("FAIL rmid_bus got %h/%h/%h want 0/0/0", mem_addr, mem_wdata, resp_rdata); end
    @(negedge clk);
    reset = 1'b1;
    nwe = 0; nresp = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_we) nwe++;
      if (resp_valid) nresp++;
    end
    checks++; if (nwe !== 0 || nresp !== 0) begin failures++; $display("FAIL rmid_aborted got we=%0d resp=%0d want 0/0", nwe, nresp); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (o_rdata !== 32'h8855AABB) begin failures++; $display("FAIL rmid_mem got %h want 8855aabb", o_rdata); end
  endtask

  task automatic test_wrap();
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_1010, 32'h0);
    checks++; if (o_rdata !== 32'h8855AABB || o_err !== 1'b0 || o_re_addr !== 10'h004) begin failures++; $display("FAIL wrap got %h err=%b addr=%h want 8855aabb/0/004", o_rdata, o_err, o_re_addr); end
  endtask

  task automatic test_back_to_back();
    logic        b_we   [3];
    logic [1:0]  b_size [3];
    logic        b_sign [3];
    logic [31:0] b_addr [3];
    logic [31:0] b_data [3];
    int          acc    [3];
    logic [31:0] res    [3];
    int idx;
    int nres;
    b_we[0] = 1'b0; b_size[0] = 2'b01; b_sign[0] = 1'b1; b_addr[0] = 32'h02; b_data[0] = 32'h0;
    b_we[1] = 1'b1; b_size[1] = 2'b10; b_sign[1] = 1'b0; b_addr[1] = 32'h20; b_data[1] = 32'hC3A55A3C;
    b_we[2] = 1'b0; b_size[2] = 2'b00; b_sign[2] = 1'b0; b_addr[2] = 32'h23; b_data[2] = 32'h0;
    idx = 0; nres = 0;
    for (int k = 0; k < 3; k++) begin acc[k] = -1; res[k] = 32'hXXXX_XXXX; end
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (resp_valid && nres < 3) begin res[nres] = resp_rdata; nres++; end
      if (idx < 3) begin
        req_we = b_we[idx]; req_size = b_size[idx]; req_sign = b_sign[idx];
        req_addr = b_addr[idx]; req_wdata = b_data[idx]; req_valid = 1'b1;
        if (req_ready) begin acc[idx] = cyc; idx++; end
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++; if (acc[0] !== 0 || acc[1] !== 4 || acc[2] !== 7) begin failures++; $display("FAIL b2b_accept got %0d/%0d/%0d want 0/4/7", acc[0], acc[1], acc[2]); end
    checks++; if (nres !== 3) begin failures++; $display("FAIL b2b_nresp got %0d want 3", nres); end
    checks++; if (res[0] !== 32'hFFFF8001) begin failures++; $display("FAIL b2b_half got %h want ffff8001", res[0]); end
    checks++; if (res[1] !== 32'h0) begin failures++; $display("FAIL b2b_store got %h want 0", res[1]); end
    checks++; if (res[2] !== 32'h000000C3) begin failures++; $display("FAIL b2b_byte got %h want 000000c3", res[2]); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_word_store();
    test_byte_load();
    test_subword_store();
    test_errors();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the CPU data-memory interface: accepts one load/store request at a time from the pipeline and drives a word-organised data memory.
- Loads: word, halfword or byte, with sign or zero extension.
- Stores: word stores are issued directly; byte and halfword stores use read-modify-write.
- Sits between the MEM stage and the data memory; the stage stalls while req_ready is low.

Parameters:
- ADDR_W, 12, byte-address bits used (4 KiB space, 1024 words); upper bits of req_addr ignored.
- DATA_W, 32, data word width; fixed at 32, no other value supported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; 0 = reset, sampled on rising edge of clk.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle, request accepted when req_valid & req_ready.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal (treated as misaligned).
- req_sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; byte/half taken from bits [7:0]/[15:0].
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  valid with resp_valid: misaligned/illegal, no memory access made.
- resp_rdata  output  32  load result, valid with resp_valid; 0 for stores and errors.
- mem_addr  output  ADDR_W-2  word address.
- mem_re  output  1  read strobe.
- mem_we  output  1  write strobe, word written at rising edge.
- mem_wdata  output  32  write data.
- mem_rdata  input  32  read data, valid the cycle after mem_re (1-cycle latency).

Behaviour:
- Reset: reset==0 at a rising edge forces state IDLE and clears all registered outputs and latched request fields. resp_valid, resp_err, resp_rdata, mem_re, mem_we, mem_wdata and mem_addr are all 0; req_ready is 1 after reset.
- Reset mid-operation aborts the operation. No mem_we is issued in any cycle following the reset edge, and no resp_valid is produced for the aborted request.
- Acceptance: at the IDLE edge where req_valid=1, the unit latches req_*. req_ready is 1 only in IDLE.
- Alignment: error if req_size==11, if req_size==01 and addr[0]==1, or if req_size==10 and addr[1:0]!=00.
- States: IDLE, RD, WAIT, WR, DONE.
- Transitions from IDLE on acceptance:
  - error -> DONE with err=1;
  - word store -> WR;
  - otherwise -> RD.
- RD: mem_re=1, mem_addr=addr[ADDR_W-1:2]. Always -> WAIT.
- WAIT: mem_rdata valid.
  - Load: extract the lane, extend, latch into resp_rdata -> DONE.
  - Sub-word store: merge store data into the word, latch into a write buffer -> WR.
- Lane selection:
  - byte lane = addr[1:0] (bits [8k+7:8k]);
  - half lane = addr[1] (bits [31:16] when 1, [15:0] when 0).
- WR: mem_we=1, mem_addr=word address, mem_wdata = merged word (sub-word) or req_wdata (word) -> DONE.
- DONE: resp_valid=1 for exactly one cycle -> IDLE.
- Latencies, counted from the acceptance edge to the resp_valid cycle:
  - error: 1 cycle;
  - word store: 2 cycles (WR, then DONE);
  - load: 3 cycles (RD, WAIT, DONE);
  - sub-word store: 4 cycles (RD, WAIT, WR, DONE).
- Strobes: mem_re and mem_we are never high in the same cycle. Each is at most one cycle per request.
- Back-to-back: a new request can be accepted at the edge leaving DONE only if the unit has returned to IDLE. The minimum gap between acceptances equals latency + 1 cycle.
- Handshake: req_* may change while req_ready=0 without effect.
- Address wrap: addresses above 2^ADDR_W alias modulo 2^ADDR_W; no error is raised.

Test Plan:
- Word store addr 0x10, data 0xDEADBEEF -> mem_we one cycle with mem_addr=0x004 and mem_wdata=0xDEADBEEF; resp_valid 2 cycles after accept with err=0.
- Memory word 0x004=0x8899AABB, signed byte load at 0x11 -> mem_re one cycle; resp_rdata=0xFFFFFFAA. Same request unsigned -> 0x000000AA.
- Memory word 0x004=0x8899AABB, byte store 0x55 at 0x12 -> read, then write with mem_wdata=0x8855AABB; total 4 cycles to resp_valid.
- Half load at 0x13 and word store at 0x12 -> resp_err=1 and resp_valid 1 cycle after accept; no mem_re/mem_we; resp_rdata=0.
- reset=0 asserted in the WAIT state of a halfword store -> no mem_we afterwards, no resp_valid; req_ready=1 and outputs 0 after the reset edge.
- Three back-to-back requests (signed half load at 0x02, word store at 0x20, unsigned byte load at 0x23) with req_valid held high -> each accepted only in IDLE; the final byte load returns the stored data's bits [31:24].
